plru_replacement_engine: RTL

//  Sequential tree-PLRU replacement engine for the LLC.
//  - Holds per-set PLRU state in an internal array (N_SETS x (N_WAY-1) bits).
//  - Serves one request at a time over a valid/ready handshake: touch, victim query, victim-and-fill, set clear.
//  - Sits between the LLC tag pipeline and the fill/evict controller.
//  - Generalises the single-set PLRU functions to N sets, any power-of-2 N_WAY, and an optional way-lock mode.

---
 rtl/plru_replacement_engine.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/plru_replacement_engine.sv
// Tree-PLRU replacement engine: per-set PLRU bits, one request at a time over valid/ready.
// Optional way-lock mode is enabled by defining PLRU_LOCK_EN, which adds the lock_mask input.
module plru_replacement_engine #(
    parameter int N_WAY  = 16,
    parameter int N_SETS = 64,
    localparam int WAY_W = $clog2(N_WAY),
    localparam int SET_W = $clog2(N_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic [N_WAY-1:0] req_valid_mask,
`ifdef PLRU_LOCK_EN
    input  logic [N_WAY-1:0] lock_mask,
`endif
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WAY_W-1:0] resp_way,
    output logic             resp_inv,
    output logic             resp_err
);
    typedef enum logic [1:0] {OP_TOUCH, OP_VICTIM, OP_FILL, OP_CLEAR} op_e;
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_RESP} state_e;

    state_e                       state, state_nx;
    logic [N_SETS-1:0][N_WAY-2:0] plru_mem;
    logic [SET_W-1:0]             init_cnt, set_q;
    op_e                          op_q;
    logic [WAY_W-1:0]             way_q;
    logic [N_WAY-1:0]             vmask_q, avail_q;

    logic [N_WAY-2:0] cur_bits, new_bits;
    logic [N_WAY-1:0] cand;
    logic [WAY_W-1:0] res_way;
    logic             res_inv, res_err, do_wr;

    // Node for level l on way w's path is (2^l - 1) + (top l bits of w).
    function automatic logic [N_WAY-2:0] mark_mru(logic [N_WAY-2:0] b, logic [WAY_W-1:0] w);
        logic [N_WAY-2:0] r;
        r = b;
        for (int l = 0; l < WAY_W; l++)
            r[(1 << l) - 1 + (int'(w) >> (WAY_W - l))] = w[WAY_W-1-l];
        return r;
    endfunction

    // Walk toward the colder side; if that subtree has no available way, take the sibling.
    function automatic logic [WAY_W-1:0] tree_victim(logic [N_WAY-2:0] b, logic [N_WAY-1:0] a);
        int   pfx;
        logic dir, any;
        pfx = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = ~b[(1 << l) - 1 + pfx];
            any = 1'b0;
            for (int i = 0; i < N_WAY; i++)
                if ((i >> (WAY_W - 1 - l)) == 2 * pfx + int'(dir)) any = any | a[i];
            if (!any) dir = ~dir;
            pfx = 2 * pfx + int'(dir);
        end
        return WAY_W'(pfx);
    endfunction

    function automatic logic [WAY_W-1:0] lowest(logic [N_WAY-1:0] c);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = N_WAY - 1; i >= 0; i--)
            if (c[i]) r = WAY_W'(i);
        return r;
    endfunction

    always_comb begin
        cur_bits = plru_mem[set_q];
        cand     = ~vmask_q & avail_q;
        new_bits = cur_bits;
        res_way  = '0;
        res_inv  = 1'b0;
        res_err  = 1'b0;
        do_wr    = 1'b0;
        case (op_q)
            OP_TOUCH: begin
                res_way = way_q;
                if (int'(way_q) >= N_WAY) begin
                    res_err = 1'b1;
                end else begin
                    do_wr    = 1'b1;
                    new_bits = mark_mru(cur_bits, way_q);
                end
            end
            OP_VICTIM, OP_FILL: begin
                if (avail_q == '0) begin
                    res_err = 1'b1;
                end else begin
                    if (cand != '0) begin
                        res_way = lowest(cand);
                        res_inv = 1'b1;
                    end else begin
                        res_way = tree_victim(cur_bits, avail_q);
                    end
                    if (op_q == OP_FILL) begin
                        do_wr    = 1'b1;
                        new_bits = mark_mru(cur_bits, res_way);
                    end
                end
            end
            default: begin
                do_wr    = 1'b1;
                new_bits = '0;
            end
        endcase
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        case (state)
            S_INIT:   if (init_cnt == SET_W'(N_SETS - 1)) state_nx = S_IDLE;
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = S_LOOKUP;
            end
            S_LOOKUP: state_nx = S_RESP;
            default:  if (resp_ready) state_nx = S_IDLE;
        endcase
    end

    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  init_cnt <= '0;
        else if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end

`ifndef PLRU_LOCK_EN
    assign avail_q = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_TOUCH;
            set_q   <= '0;
            way_q   <= '0;
            vmask_q <= '1;
`ifdef PLRU_LOCK_EN
            avail_q <= '1;
`endif
        end else if (state == S_IDLE && req_valid) begin
            op_q    <= op_e'(req_op);
            set_q   <= req_set;
            way_q   <= req_way;
            vmask_q <= req_valid_mask;
`ifdef PLRU_LOCK_EN
            avail_q <= ~lock_mask;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_way <= '0;
            resp_inv <= 1'b0;
            resp_err <= 1'b0;
        end else if (state == S_LOOKUP) begin
            resp_way <= res_way;
            resp_inv <= res_inv;
            resp_err <= res_err;
        end
    end

    // PLRU storage is cleared by the INIT sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            plru_mem[init_cnt] <= '0;
        else if (state == S_LOOKUP && do_wr)
            plru_mem[set_q] <= new_bits;
    end
endmodule
